// File: rtl/fir_pkg.sv
// Shared defaults and derived widths for the FIR tap accumulator.
// Also holds the tap-sequencing state encoding.
package fir_pkg;

    localparam int DEF_PROD_WIDTH     = 34;
    localparam int DEF_NUM_TAPS       = 8;
    localparam int DEF_OUT_DATA_WIDTH = 21;
    localparam int DEF_SHIFT          = 13;

    // Headroom of log2(taps) bits makes the full sum overflow-free.
    function automatic int acc_width(input int pw, input int nt);
        return pw + $clog2(nt);
    endfunction

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } tap_state_t;

endpackage

// File: rtl/fir_round_sat.sv
// Round-half-up, arithmetic shift and saturate a completed sum.
// Purely combinational; the caller registers the result.
module fir_round_sat
    import fir_pkg::*;
#(
    parameter int ACC_WIDTH      = acc_width(DEF_PROD_WIDTH, DEF_NUM_TAPS),
    parameter int OUT_DATA_WIDTH = DEF_OUT_DATA_WIDTH,
    parameter int SHIFT          = DEF_SHIFT
) (
    input  logic [ACC_WIDTH-1:0]      acc,
    output logic [OUT_DATA_WIDTH-1:0] data,
    output logic                      sat
);

    localparam int EW = ACC_WIDTH + 1;

    localparam logic signed [EW-1:0] HALF =
        EW'(64'sd1 <<< (SHIFT - 1));
    localparam logic signed [EW-1:0] MAXV =
        EW'((64'sd1 <<< (OUT_DATA_WIDTH - 1)) - 64'sd1);
    localparam logic signed [EW-1:0] MINV =
        EW'(-(64'sd1 <<< (OUT_DATA_WIDTH - 1)));

    logic signed [EW-1:0] biased;
    logic signed [EW-1:0] shifted;

    // One guard bit keeps the rounding bias from wrapping the top of range.
    assign biased  = $signed({acc[ACC_WIDTH-1], acc}) + HALF;
    assign shifted = biased >>> SHIFT;

    always_comb begin
        data = shifted[OUT_DATA_WIDTH-1:0];
        sat  = 1'b0;
        if (shifted > MAXV) begin
            data = MAXV[OUT_DATA_WIDTH-1:0];
            sat  = 1'b1;
        end else if (shifted < MINV) begin
            data = MINV[OUT_DATA_WIDTH-1:0];
            sat  = 1'b1;
        end
    end

endmodule

// File: rtl/fir_tap_accum.sv
// Sums NUM_TAPS tap products per output sample, then rounds,
// saturates and emits one registered sample per completed sum.
module fir_tap_accum
    import fir_pkg::*;
#(
    parameter int PROD_WIDTH     = DEF_PROD_WIDTH,
    parameter int NUM_TAPS       = DEF_NUM_TAPS,
    parameter int OUT_DATA_WIDTH = DEF_OUT_DATA_WIDTH,
    parameter int SHIFT          = DEF_SHIFT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_prod_vld,
    input  logic [PROD_WIDTH-1:0]     in_prod,
    input  logic                      clear,
    output logic [OUT_DATA_WIDTH-1:0] out_data,
    output logic                      out_data_vld,
    output logic                      out_sat
);

    localparam int ACC_WIDTH = acc_width(PROD_WIDTH, NUM_TAPS);
    localparam int CW        = $clog2(NUM_TAPS);
    localparam logic [CW-1:0] LAST = CW'(NUM_TAPS - 1);

    tap_state_t state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic acc_load;
    logic acc_add;
    logic last;

    logic [ACC_WIDTH-1:0] prod_ext;
    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] sum;
    logic [ACC_WIDTH-1:0] final_sum;
    logic                 done;

    logic [OUT_DATA_WIDTH-1:0] rs_data;
    logic                      rs_sat;
    logic [OUT_DATA_WIDTH-1:0] pipe_data;
    logic                      pipe_sat;
    logic                      pipe_vld;

    assign prod_ext = {{(ACC_WIDTH - PROD_WIDTH){in_prod[PROD_WIDTH-1]}},
                       in_prod};
    assign sum      = acc + prod_ext;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // A clear that coincides with a product restarts the sum on that product.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        acc_load  = 1'b0;
        acc_add   = 1'b0;
        last      = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (in_prod_vld) begin
                    acc_load  = 1'b1;
                    cnt_nxt   = CW'(1);
                    state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                if (clear) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                    if (in_prod_vld) begin
                        acc_load  = 1'b1;
                        cnt_nxt   = CW'(1);
                        state_nxt = ACCUM;
                    end
                end else if (in_prod_vld) begin
                    acc_add = 1'b1;
                    if (cnt == LAST) begin
                        last      = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc       <= '0;
            final_sum <= '0;
            done      <= 1'b0;
        end else begin
            if (acc_load) begin
                acc <= prod_ext;
            end else if (acc_add) begin
                acc <= sum;
            end
            if (last) begin
                final_sum <= sum;
            end
            done <= last;
        end
    end

    fir_round_sat #(
        .ACC_WIDTH      (ACC_WIDTH),
        .OUT_DATA_WIDTH (OUT_DATA_WIDTH),
        .SHIFT          (SHIFT)
    ) u_round_sat (
        .acc  (final_sum),
        .data (rs_data),
        .sat  (rs_sat)
    );

    // Clear never reaches past the final register, so results in flight survive it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pipe_data    <= '0;
            pipe_sat     <= 1'b0;
            pipe_vld     <= 1'b0;
            out_data     <= '0;
            out_sat      <= 1'b0;
            out_data_vld <= 1'b0;
        end else begin
            pipe_vld <= done;
            if (done) begin
                pipe_data <= rs_data;
                pipe_sat  <= rs_sat;
            end
            out_data_vld <= pipe_vld;
            if (pipe_vld) begin
                out_data <= pipe_data;
                out_sat  <= pipe_sat;
            end
        end
    end

endmodule

// File: doc/fir_tap_accum.md
FIR_TAP_ACCUM -- requirements
Module: fir_tap_accum

Interface
REQ-001 SHALL have parameter PROD_WIDTH, default 34: width of signed tap product input.
REQ-002 SHALL have parameter NUM_TAPS, default 8: products summed per output sample; power of two, at least 2.
REQ-003 SHALL have parameter OUT_DATA_WIDTH, default 21: width of signed filter output.
REQ-004 SHALL have parameter SHIFT, default 13: right-shift applied to the sum before saturation.
REQ-005 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-007 SHALL have port in_prod_vld  input  1  in_prod is valid this cycle.
REQ-008 SHALL have port in_prod  input  PROD_WIDTH  two's-complement tap product from the multiplier stage.
REQ-009 SHALL have port clear  input  1  synchronous discard of any partial sum.
REQ-010 SHALL have port out_data  output  OUT_DATA_WIDTH  rounded, saturated filter sample, two's complement.
REQ-011 SHALL have port out_data_vld  output  1  single-cycle pulse qualifying out_data.
REQ-012 SHALL have port out_sat  output  1  out_data was clipped; qualified by out_data_vld.

Function
REQ-013 SHALL accumulate in ACC_WIDTH = PROD_WIDTH + log2(NUM_TAPS) bits, sign-extending each product; no internal overflow possible.
REQ-014 SHALL keep tap counter 0..NUM_TAPS-1; each accepted product increments it; wraps to 0 after the NUM_TAPS-th product.
REQ-015 SHALL load the accumulator with the product (not add) when counter is 0; otherwise add.
REQ-016 SHALL, on the NUM_TAPS-th product, latch the completed sum into a separate final register and raise an internal done flag for one cycle.
REQ-017 SHALL compute from the final register: add 2^(SHIFT-1), arithmetic shift right by SHIFT (round half toward +infinity).
REQ-018 SHALL saturate the shifted value to [-2^(OUT_DATA_WIDTH-1), 2^(OUT_DATA_WIDTH-1)-1] and set out_sat when clipping occurs.
REQ-019 SHALL register out_data, out_sat, out_data_vld; out_data_vld rises exactly 2 cycles after the clock edge sampling the last product and lasts 1 cycle.
REQ-020 SHALL hold out_data and out_sat at last value when out_data_vld is low.
REQ-021 SHALL accept a new product every cycle, including the cycle the final register loads; back-to-back sums produce outputs NUM_TAPS cycles apart.
REQ-022 SHALL tolerate arbitrary gaps (in_prod_vld low); counter and accumulator hold.
REQ-023 SHALL, on clear, set counter to 0; clear with in_prod_vld in the same cycle starts a fresh sum with that product (counter becomes 1).
REQ-024 SHALL NOT let clear cancel an output already latched in the final register or output pipeline.
REQ-025 SHALL use states IDLE (counter 0, no partial) and ACCUM (partial sum held); IDLE->ACCUM on accepted product, ACCUM->IDLE on last product or clear.

Reset
REQ-026 SHALL, while reset is 0, asynchronously force counter 0, state IDLE, accumulator 0, final register 0, done 0, out_data 0, out_sat 0, out_data_vld 0.
REQ-027 SHALL discard any partial sum and pending output when reset asserts mid-operation; first output after release needs NUM_TAPS new products.

Structure
REQ-028 SHALL take PROD_WIDTH, OUT_DATA_WIDTH, NUM_TAPS, SHIFT defaults and the ACC_WIDTH derivation from shared package fir_pkg.
REQ-029 SHALL implement rounding and saturation (REQ-017, REQ-018) in combinational sub-module fir_round_sat, instantiated once.

Verification
REQ-030 Eight products of 8192, consecutive -> one out_data_vld pulse 2 cycles after the 8th, out_data 8, out_sat 0.
REQ-031 One product 4096 then seven of 0 -> out_data 1; one product -4096 then seven of 0 -> out_data 0 (rounding check).
REQ-032 Eight of 8589934591 -> out_data 1048575, out_sat 1; eight of -8589934591 -> out_data -1048576, out_sat 1.
REQ-033 Three of 8192, clear, then eight of 8192 with random vld gaps -> exactly one output, value 8.
REQ-034 Sixteen consecutive products of 8192 -> two outputs of 8, exactly 8 cycles apart.
REQ-035 Five products, reset low 1 cycle, then eight of 8192 -> all outputs 0 during reset, then one output of 8.
